// File: rtl/bist_controller_pkg.sv
// rtl/bist_controller_pkg.sv - shared state encoding, tap positions and shift helper for the BIST sequencer
package bist_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_RUN     = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } bist_state_t;

    // x^4 + x^3 + 1: feedback taken from bits 3 and 2, shared by LFSR and MISR
    localparam int SHIFT_TAP_HI = 3;
    localparam int SHIFT_TAP_LO = 2;

    localparam logic [3:0] DEFAULT_SEED = 4'b0001;

    // One shift of the 4-bit register with XOR feedback into bit 0
    function automatic logic [3:0] shift4(input logic [3:0] v);
        return {v[2:0], v[SHIFT_TAP_HI] ^ v[SHIFT_TAP_LO]};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - 4-bit Fibonacci LFSR pattern generator with synchronous load
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (state returns to RESET_VAL)
//   load       - load seed on the next edge (wins over enable)
//   enable     - advance one step on the next edge
//   seed       - value loaded when load=1
//   state      - current LFSR contents
module bist_lfsr
    import bist_controller_pkg::*;
#(
    parameter logic [3:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       enable,
    input  logic [3:0] seed,
    output logic [3:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= seed;
        end else if (enable) begin
            state <= shift4(state);
        end
    end

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - BIST sequencer: LFSR patterns to the CUT, MISR compaction, golden compare
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - run request, honoured in IDLE or DONE
//   abort      - cancels a run in SEED/RUN/COMPARE; beats start everywhere
//   cut_in     - pattern {a,b,c,d} driven to the CUT (straight from the LFSR)
//   cut_out    - CUT response {i,j}
//   busy       - high in SEED, RUN, COMPARE
//   done       - high in DONE
//   pass       - compare result, meaningful while done=1
//   signature  - current MISR contents
module bist_controller
    import bist_controller_pkg::*;
#(
    parameter int         N_PATTERNS = 15,
    parameter int         CNT_W      = 4,
    parameter logic [3:0] LFSR_SEED  = DEFAULT_SEED,
    parameter logic [3:0] GOLDEN_SIG = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] cut_in,
    input  logic [1:0] cut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] signature
);

    // Counter value at the edge that captures the final response
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((N_PATTERNS == 0) ? 0 : N_PATTERNS - 1);

    bist_state_t      state_q, state_d;
    logic [3:0]       misr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pass_q;
    logic             seed_load;
    logic             run_step;
    logic [3:0]       lfsr_q;

    bist_lfsr #(
        .RESET_VAL(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (seed_load),
        .enable (run_step),
        .seed   (LFSR_SEED),
        .state  (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seed_load = 1'b0;
        run_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) state_d = ST_SEED;
            end
            ST_SEED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    seed_load = 1'b1;
                    state_d   = (N_PATTERNS == 0) ? ST_COMPARE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    run_step = 1'b1;
                    if (cnt_q == LAST_CNT) state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                state_d = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (start && !abort) state_d = ST_SEED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An aborting RUN cycle does not capture, so the MISR keeps its partial value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= '0;
            cnt_q  <= '0;
        end else if (seed_load) begin
            misr_q <= '0;
            cnt_q  <= '0;
        end else if (run_step) begin
            misr_q <= shift4(misr_q) ^ {2'b00, cut_out};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else if (state_q == ST_COMPARE && !abort) begin
            pass_q <= (misr_q == GOLDEN_SIG);
        end else if (state_d == ST_SEED || state_d == ST_IDLE) begin
            pass_q <= 1'b0;
        end
    end

    assign cut_in    = lfsr_q;
    assign busy      = (state_q == ST_SEED) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - self-checking bench for bist_controller against a pattern/signature model
module tb_bist_controller;

    logic clk;
    logic rst_n;

    // a: N=15 golden 0 with random CUT table; b: N=3 golden 7; c: N=3 golden 0; d: N=0 golden 0
    logic       start_a, abort_a, busy_a, done_a, pass_a;
    logic [3:0] cut_in_a, sig_a;
    logic [1:0] cut_out_a;
    logic       start_b, abort_b, busy_b, done_b, pass_b;
    logic [3:0] cut_in_b, sig_b;
    logic       start_c, abort_c, busy_c, done_c, pass_c;
    logic [3:0] cut_in_c, sig_c;
    logic       start_d, abort_d, busy_d, done_d, pass_d;
    logic [3:0] cut_in_d, sig_d;

    logic [1:0] cut_tbl [16];
    logic [3:0] seq [15];

    int checks = 0;
    int errors = 0;

    assign cut_out_a = cut_tbl[cut_in_a];

    bist_controller #(.N_PATTERNS(15), .GOLDEN_SIG(4'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .cut_in(cut_in_a),
        .cut_out(cut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));
    bist_controller #(.N_PATTERNS(3), .GOLDEN_SIG(4'h7)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .cut_in(cut_in_b),
        .cut_out(2'b01), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));
    bist_controller #(.N_PATTERNS(3), .GOLDEN_SIG(4'h0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .cut_in(cut_in_c),
        .cut_out(2'b01), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));
    bist_controller #(.N_PATTERNS(0), .GOLDEN_SIG(4'h0)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d), .cut_in(cut_in_d),
        .cut_out(2'b01), .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Signature after n captures; stuck=1 models the CUT with cut_out fixed at 2'b01
    function automatic logic [3:0] model_sig(input int n, input bit stuck);
        int m = 0;
        int r;
        for (int k = 0; k < n; k++) begin
            r = stuck ? 1 : int'(cut_tbl[seq[k % 15]]);
            m = (((m << 1) | (((m >> 3) ^ (m >> 2)) & 1)) & 15) ^ r;
        end
        return 4'(m);
    endfunction

    task automatic new_table;
        for (int i = 0; i < 16; i++) cut_tbl[i] = 2'($urandom_range(0, 3));
    endtask

    // Full 15-pattern run on instance a; optional stray start in the middle of RUN
    task automatic run_a(input bit stray_start);
        logic [3:0] exp_sig;
        exp_sig = model_sig(15, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_seed_busy", 8'(busy_a), 8'd1);
        for (int k = 0; k < 15; k++) begin
            if (stray_start && k == 5) start_a = 1'b1;
            tick();
            start_a = 1'b0;
            chk($sformatf("a_cut_in[%0d]", k), 8'(cut_in_a), 8'(seq[k]));
        end
        tick();
        chk("a_compare_done_low", 8'({busy_a, done_a}), 8'b10);
        tick();
        chk("a_done_edge17", 8'({busy_a, done_a}), 8'b01);
        chk("a_signature", 8'(sig_a), 8'(exp_sig));
        chk("a_pass", 8'(pass_a), 8'(exp_sig == 4'h0));
        tick();
        chk("a_done_held", 8'({done_a, sig_a}), 8'({1'b1, exp_sig}));
    endtask

    initial begin
        seq = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
        new_table();
        rst_n = 1'b0;
        {start_a, abort_a, start_b, abort_b, start_c, abort_c, start_d, abort_d} = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("reset_state", 8'({busy_a, done_a, pass_a, sig_a}), 8'h00);
        chk("reset_cut_in", 8'(cut_in_a), 8'h01);

        // Async reset in the middle of a run
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        chk("a_midrun_busy", 8'(busy_a), 8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", 8'({busy_a, done_a, pass_a}), 8'h0);
        chk("async_rst_sig", 8'(sig_a), 8'h0);
        chk("async_rst_cut_in", 8'(cut_in_a), 8'h1);
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_hold", 8'({busy_a, done_a, cut_in_a}), 8'h01);
        end

        run_a(1'b1);

        // Abort in the third RUN cycle with a fresh random CUT
        new_table();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_flags", 8'({busy_a, done_a, pass_a}), 8'h0);
        chk("abort_partial_sig", 8'(sig_a), 8'(model_sig(2, 1'b0)));
        tick();
        chk("abort_stays_idle", 8'({busy_a, done_a}), 8'h0);
        run_a(1'b0);

        // N=3 with the stuck CUT: golden 7 passes, golden 0 fails
        start_b = 1'b1;
        start_c = 1'b1;
        tick();
        start_b = 1'b0;
        start_c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("b_sig_step%0d", k), 8'(sig_b), 8'(model_sig(k, 1'b1)));
        end
        chk("b_sig_final7", 8'(sig_b), 8'h07);
        tick();
        chk("b_done_pass", 8'({done_b, pass_b}), 8'b11);
        chk("c_done_fail", 8'({done_c, pass_c, sig_c}), 8'({1'b1, 1'b0, 4'h7}));

        // abort beats start in DONE; plain start restarts and clears pass
        start_b = 1'b1;
        abort_b = 1'b1;
        start_c = 1'b1;
        tick();
        {start_b, abort_b, start_c} = '0;
        chk("b_abort_wins_done", 8'({done_b, pass_b, busy_b}), 8'b110);
        chk("c_restart_seed", 8'({busy_c, done_c, pass_c}), 8'b100);

        // N=0: SEED -> COMPARE -> DONE
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        chk("d_seed", 8'({busy_d, done_d}), 8'b10);
        tick();
        chk("d_compare", 8'({busy_d, done_d}), 8'b10);
        tick();
        chk("d_done", 8'({done_d, pass_d, sig_d}), 8'({1'b1, 1'b1, 4'h0}));
        #3 rst_n = 1'b0;
        #1;
        chk("d_async_clear", 8'({done_d, pass_d, busy_d}), 8'h0);
        chk("b_async_clear", 8'({done_b, pass_b}), 8'h0);
        #2 rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
